// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Shared definitions for the guesser-side game blocks:
//   - round_timer FSM state encoding
//   - default round durations and the timer_sel encoding used by the
//     timer-select menu
//   - hint-level width shared with the letter cycler
//   - seconds threshold for the optional warning blink
// -----------------------------------------------------------------------------
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_EXPIRED = 2'd2,
        ST_SOLVED  = 2'd3
    } rt_state_e;

    // Default round lengths in seconds, one per timer_sel code
    localparam int DUR0_DEF = 40;
    localparam int DUR1_DEF = 60;
    localparam int DUR2_DEF = 80;
    localparam int DUR3_DEF = 120;

    // timer_sel encoding
    localparam logic [1:0] TSEL_DUR0 = 2'd0;
    localparam logic [1:0] TSEL_DUR1 = 2'd1;
    localparam logic [1:0] TSEL_DUR2 = 2'd2;
    localparam logic [1:0] TSEL_DUR3 = 2'd3;

    // hint_level width, fixed so MAX_HINT can range 1..7
    localparam int HINT_W       = 3;
    localparam int MAX_HINT_DEF = 3;

    // Seconds remaining at or below which the warning blink runs
    localparam int WARN_SECS = 10;

    // Seconds between hints: the round is split into MAX_HINT+1 equal slices
    function automatic int hint_interval(input int dur, input int max_hint);
        return dur / (max_hint + 1);
    endfunction

endpackage

// File: rtl/sec_down_counter.sv
// -----------------------------------------------------------------------------
// sec_down_counter
// Loadable down-counter with tick enable. Counts down by one on each dec_i,
// saturating at zero. Priority: reset > clr_i > load_i > dec_i.
//
// Ports:
//   clk         in   clock
//   reset       in   synchronous, active-high; clears the count
//   clr_i       in   clear count to 0
//   load_i      in   load load_val_i
//   load_val_i  in   value to load (W bits)
//   dec_i       in   decrement enable (ignored at zero)
//   cnt_o       out  current count (W bits)
//   zero_o      out  count == 0
//   one_o       out  count == 1
// -----------------------------------------------------------------------------
module sec_down_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o,
    output logic         zero_o,
    output logic         one_o
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);
    assign one_o  = (cnt_q == ONE);

endmodule

// File: rtl/round_timer.sv
// -----------------------------------------------------------------------------
// round_timer
// Per-round countdown and hint scheduler for the guesser side. Counts the
// round down on the 1 Hz strobe, releases a hint every DURn/(MAX_HINT+1)
// seconds, and reports expiry or a solved round to the state controller.
//
// Optional build macro: ROUND_TIMER_WARN_EN adds warn_blink, which toggles
// on every tick while running with 10 s or less left.
//
// Ports:
//   clk           in   system clock
//   reset         in   synchronous, active-high
//   tick_1hz      in   one-cycle strobe, once per second
//   game_start    in   level, high while the canvas phase is active
//   word_correct  in   guesser solved the word (level or pulse)
//   timer_sel     in   duration select, sampled on game_start rise
//   timer_done    out  round expired (level)
//   hint_start    out  high once any hint has been released this round
//   hint_level    out  hints released so far, 0..MAX_HINT
//   seconds_left  out  remaining seconds (SEC_W bits)
//   round_solved  out  word guessed before expiry (level)
//   warn_blink    out  low-time warning blink (ROUND_TIMER_WARN_EN only)
// -----------------------------------------------------------------------------
module round_timer
    import game_pkg::*;
#(
    parameter int DUR0     = DUR0_DEF,
    parameter int DUR1     = DUR1_DEF,
    parameter int DUR2     = DUR2_DEF,
    parameter int DUR3     = DUR3_DEF,
    parameter int MAX_HINT = MAX_HINT_DEF,
    parameter int SEC_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick_1hz,
    input  logic              game_start,
    input  logic              word_correct,
    input  logic [1:0]        timer_sel,
    output logic              timer_done,
    output logic              hint_start,
    output logic [HINT_W-1:0] hint_level,
    output logic [SEC_W-1:0]  seconds_left,
    output logic              round_solved
`ifdef ROUND_TIMER_WARN_EN
    ,
    output logic              warn_blink
`endif
);

    localparam logic [SEC_W-1:0] DUR0_V = SEC_W'(DUR0);
    localparam logic [SEC_W-1:0] DUR1_V = SEC_W'(DUR1);
    localparam logic [SEC_W-1:0] DUR2_V = SEC_W'(DUR2);
    localparam logic [SEC_W-1:0] DUR3_V = SEC_W'(DUR3);

    localparam logic [SEC_W-1:0] INT0_V = SEC_W'(hint_interval(DUR0, MAX_HINT));
    localparam logic [SEC_W-1:0] INT1_V = SEC_W'(hint_interval(DUR1, MAX_HINT));
    localparam logic [SEC_W-1:0] INT2_V = SEC_W'(hint_interval(DUR2, MAX_HINT));
    localparam logic [SEC_W-1:0] INT3_V = SEC_W'(hint_interval(DUR3, MAX_HINT));

    localparam logic [HINT_W-1:0] MAX_HINT_V = HINT_W'(MAX_HINT);

    function automatic logic [SEC_W-1:0] dur_of(input logic [1:0] sel);
        logic [SEC_W-1:0] v;
        unique case (sel)
            TSEL_DUR0: v = DUR0_V;
            TSEL_DUR1: v = DUR1_V;
            TSEL_DUR2: v = DUR2_V;
            default:   v = DUR3_V;
        endcase
        return v;
    endfunction

    function automatic logic [SEC_W-1:0] int_of(input logic [1:0] sel);
        logic [SEC_W-1:0] v;
        unique case (sel)
            TSEL_DUR0: v = INT0_V;
            TSEL_DUR1: v = INT1_V;
            TSEL_DUR2: v = INT2_V;
            default:   v = INT3_V;
        endcase
        return v;
    endfunction

    rt_state_e         state_q, state_d;
    logic [1:0]        sel_q, sel_d;
    logic              game_start_q;
    logic              timer_done_q, timer_done_d;
    logic              hint_start_q, hint_start_d;
    logic [HINT_W-1:0] hint_level_q, hint_level_d;
    logic              round_solved_q, round_solved_d;
    logic              go_idle;

    logic              sec_clr, sec_load, sec_dec;
    logic [SEC_W-1:0]  sec_load_val, sec_cnt;
    logic              sec_zero, sec_one;

    logic              hint_clr, hint_load, hint_dec;
    logic [SEC_W-1:0]  hint_load_val, hint_cnt;
    logic              hint_zero, hint_one;

`ifdef ROUND_TIMER_WARN_EN
    localparam logic [SEC_W-1:0] WARN_V = SEC_W'(WARN_SECS);
    logic             warn_q, warn_d;
    logic [SEC_W-1:0] sec_minus1;
    assign sec_minus1 = sec_cnt - {{(SEC_W-1){1'b0}}, 1'b1};
`endif

    wire gs_rise = game_start & ~game_start_q;

    sec_down_counter #(.W(SEC_W)) u_sec (
        .clk        (clk),
        .reset      (reset),
        .clr_i      (sec_clr),
        .load_i     (sec_load),
        .load_val_i (sec_load_val),
        .dec_i      (sec_dec),
        .cnt_o      (sec_cnt),
        .zero_o     (sec_zero),
        .one_o      (sec_one)
    );

    sec_down_counter #(.W(SEC_W)) u_hint (
        .clk        (clk),
        .reset      (reset),
        .clr_i      (hint_clr),
        .load_i     (hint_load),
        .load_val_i (hint_load_val),
        .dec_i      (hint_dec),
        .cnt_o      (hint_cnt),
        .zero_o     (hint_zero),
        .one_o      (hint_one)
    );

    always_comb begin
        state_d        = state_q;
        sel_d          = sel_q;
        timer_done_d   = timer_done_q;
        hint_start_d   = hint_start_q;
        hint_level_d   = hint_level_q;
        round_solved_d = round_solved_q;
        go_idle        = 1'b0;
        sec_clr        = 1'b0;
        sec_load       = 1'b0;
        sec_dec        = 1'b0;
        sec_load_val   = dur_of(timer_sel);
        hint_clr       = 1'b0;
        hint_load      = 1'b0;
        hint_dec       = 1'b0;
        hint_load_val  = int_of(sel_q);
`ifdef ROUND_TIMER_WARN_EN
        warn_d         = warn_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                // A tick coinciding with the rise is dropped: only the load happens.
                if (gs_rise) begin
                    state_d       = ST_RUN;
                    sel_d         = timer_sel;
                    sec_load      = 1'b1;
                    hint_load     = 1'b1;
                    hint_load_val = int_of(timer_sel);
`ifdef ROUND_TIMER_WARN_EN
                    warn_d        = (dur_of(timer_sel) <= WARN_V);
`endif
                end
            end

            ST_RUN: begin
                if (!game_start) begin
                    go_idle = 1'b1;
                end else if (word_correct) begin
                    state_d        = ST_SOLVED;
                    round_solved_d = 1'b1;
`ifdef ROUND_TIMER_WARN_EN
                    warn_d         = 1'b0;
`endif
                end else if (tick_1hz && sec_one) begin
                    // Final tick: expiry wins over a hint due on the same tick.
                    state_d      = ST_EXPIRED;
                    sec_dec      = 1'b1;
                    timer_done_d = 1'b1;
`ifdef ROUND_TIMER_WARN_EN
                    warn_d       = 1'b0;
`endif
                end else if (tick_1hz && !sec_zero) begin
                    sec_dec = 1'b1;
                    // A zero interval (round shorter than MAX_HINT+1 s) also reloads.
                    if (hint_one || hint_zero) begin
                        hint_load = 1'b1;
                        if (hint_level_q < MAX_HINT_V) begin
                            hint_level_d = hint_level_q + 1'b1;
                            hint_start_d = 1'b1;
                        end
                    end else begin
                        hint_dec = 1'b1;
                    end
`ifdef ROUND_TIMER_WARN_EN
                    if (sec_cnt <= WARN_V) begin
                        warn_d = ~warn_q;
                    end else if (sec_minus1 <= WARN_V) begin
                        warn_d = 1'b1;
                    end
`endif
                end
            end

            ST_EXPIRED, ST_SOLVED: begin
                if (!game_start) begin
                    go_idle = 1'b1;
                end
            end

            default: begin
                go_idle = 1'b1;
            end
        endcase

        if (go_idle) begin
            state_d        = ST_IDLE;
            timer_done_d   = 1'b0;
            hint_start_d   = 1'b0;
            hint_level_d   = '0;
            round_solved_d = 1'b0;
            sec_clr        = 1'b1;
            hint_clr       = 1'b1;
            sec_dec        = 1'b0;
            hint_load      = 1'b0;
            hint_dec       = 1'b0;
`ifdef ROUND_TIMER_WARN_EN
            warn_d         = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            sel_q          <= '0;
            // Seeded high so a game_start held across reset is not seen as a rise.
            game_start_q   <= 1'b1;
            timer_done_q   <= 1'b0;
            hint_start_q   <= 1'b0;
            hint_level_q   <= '0;
            round_solved_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            sel_q          <= sel_d;
            game_start_q   <= game_start;
            timer_done_q   <= timer_done_d;
            hint_start_q   <= hint_start_d;
            hint_level_q   <= hint_level_d;
            round_solved_q <= round_solved_d;
        end
    end

`ifdef ROUND_TIMER_WARN_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            warn_q <= 1'b0;
        end else begin
            warn_q <= warn_d;
        end
    end
    assign warn_blink = warn_q;
`endif

    assign timer_done   = timer_done_q;
    assign hint_start   = hint_start_q;
    assign hint_level   = hint_level_q;
    assign seconds_left = sec_cnt;
    assign round_solved = round_solved_q;

endmodule

// File: tb/tb_round_timer.sv
module tb_round_timer;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick_1hz;
    logic       game_start;
    logic       word_correct;
    logic [1:0] timer_sel;
    logic       timer_done;
    logic       hint_start;
    logic [2:0] hint_level;
    logic [7:0] seconds_left;
    logic       round_solved;
`ifdef ROUND_TIMER_WARN_EN
    logic       warn_blink;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    round_timer dut (
        .clk          (clk),
        .reset        (reset),
        .tick_1hz     (tick_1hz),
        .game_start   (game_start),
        .word_correct (word_correct),
        .timer_sel    (timer_sel),
        .timer_done   (timer_done),
        .hint_start   (hint_start),
        .hint_level   (hint_level),
        .seconds_left (seconds_left),
        .round_solved (round_solved)
`ifdef ROUND_TIMER_WARN_EN
        ,
        .warn_blink   (warn_blink)
`endif
    );

    // All tasks start and end at a falling edge: inputs change there and the
    // outputs of the preceding rising edge are read there.
    task automatic do_tick();
        tick_1hz = 1'b1;
        @(negedge clk);
        tick_1hz = 1'b0;
    endtask

    task automatic start_round(input logic [1:0] sel);
        timer_sel  = sel;
        game_start = 1'b1;
        @(negedge clk);
    endtask

    task automatic end_round();
        game_start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        total++; if (seconds_left !== 8'd0) begin bad++; $display("FAIL reset_sec got=%0d exp=0", seconds_left); end
        total++; if (timer_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", timer_done); end
        total++; if (hint_start !== 1'b0) begin bad++; $display("FAIL reset_hs got=%b exp=0", hint_start); end
        total++; if (hint_level !== 3'd0) begin bad++; $display("FAIL reset_hl got=%0d exp=0", hint_level); end
        total++; if (round_solved !== 1'b0) begin bad++; $display("FAIL reset_solved got=%b exp=0", round_solved); end
    endtask

    task automatic test_full_expiry();
        int exp_hl;
        // tick coincident with the rise must be ignored
        timer_sel  = 2'd0;
        game_start = 1'b1;
        tick_1hz   = 1'b1;
        @(negedge clk);
        tick_1hz = 1'b0;
        total++; if (seconds_left !== 8'd40) begin bad++; $display("FAIL exp_load got=%0d exp=40", seconds_left); end
        total++; if (hint_level !== 3'd0) begin bad++; $display("FAIL exp_load_hl got=%0d exp=0", hint_level); end
        for (int t = 1; t <= 40; t++) begin
            do_tick();
            exp_hl = (t / 10 > 3) ? 3 : t / 10;
            total++; if (seconds_left !== 8'(40 - t)) begin bad++; $display("FAIL exp_sec t=%0d got=%0d exp=%0d", t, seconds_left, 40 - t); end
            total++; if (hint_level !== 3'(exp_hl)) begin bad++; $display("FAIL exp_hl t=%0d got=%0d exp=%0d", t, hint_level, exp_hl); end
            total++; if (hint_start !== (t >= 10)) begin bad++; $display("FAIL exp_hs t=%0d got=%b exp=%b", t, hint_start, t >= 10); end
            total++; if (timer_done !== (t == 40)) begin bad++; $display("FAIL exp_done t=%0d got=%b exp=%b", t, timer_done, t == 40); end
        end
        repeat (3) do_tick();
        total++; if (seconds_left !== 8'd0) begin bad++; $display("FAIL exp_hold_sec got=%0d exp=0", seconds_left); end
        total++; if (timer_done !== 1'b1) begin bad++; $display("FAIL exp_hold_done got=%b exp=1", timer_done); end
        total++; if (hint_level !== 3'd3) begin bad++; $display("FAIL exp_hold_hl got=%0d exp=3", hint_level); end
    endtask

    task automatic test_rearm();
        end_round();
        total++; if (timer_done !== 1'b0) begin bad++; $display("FAIL rearm_done_clr got=%b exp=0", timer_done); end
        total++; if (hint_level !== 3'd0) begin bad++; $display("FAIL rearm_hl_clr got=%0d exp=0", hint_level); end
        total++; if (hint_start !== 1'b0) begin bad++; $display("FAIL rearm_hs_clr got=%b exp=0", hint_start); end
        start_round(2'd3);
        total++; if (seconds_left !== 8'd120) begin bad++; $display("FAIL rearm_sec got=%0d exp=120", seconds_left); end
        total++; if (hint_level !== 3'd0) begin bad++; $display("FAIL rearm_hl got=%0d exp=0", hint_level); end
        total++; if (timer_done !== 1'b0) begin bad++; $display("FAIL rearm_done got=%b exp=0", timer_done); end
        repeat (29) do_tick();
        total++; if (hint_level !== 3'd0) begin bad++; $display("FAIL rearm_hl29 got=%0d exp=0", hint_level); end
        do_tick();
        total++; if (hint_level !== 3'd1) begin bad++; $display("FAIL rearm_hl30 got=%0d exp=1", hint_level); end
        total++; if (seconds_left !== 8'd90) begin bad++; $display("FAIL rearm_sec30 got=%0d exp=90", seconds_left); end
        // fall together with a tick: goes idle, tick dropped
        game_start = 1'b0;
        tick_1hz   = 1'b1;
        @(negedge clk);
        tick_1hz = 1'b0;
        total++; if (seconds_left !== 8'd0) begin bad++; $display("FAIL fall_tick_sec got=%0d exp=0", seconds_left); end
        total++; if (hint_level !== 3'd0) begin bad++; $display("FAIL fall_tick_hl got=%0d exp=0", hint_level); end
    endtask

    task automatic test_solve();
        start_round(2'd1);
        timer_sel = 2'd0;  // must not affect the running round
        repeat (10) do_tick();
        total++; if (hint_level !== 3'd0) begin bad++; $display("FAIL solve_hl10 got=%0d exp=0", hint_level); end
        repeat (10) do_tick();
        total++; if (seconds_left !== 8'd40) begin bad++; $display("FAIL solve_sec20 got=%0d exp=40", seconds_left); end
        total++; if (hint_level !== 3'd1) begin bad++; $display("FAIL solve_hl20 got=%0d exp=1", hint_level); end
        word_correct = 1'b1;
        @(negedge clk);
        word_correct = 1'b0;
        total++; if (round_solved !== 1'b1) begin bad++; $display("FAIL solve_flag got=%b exp=1", round_solved); end
        repeat (25) do_tick();
        total++; if (seconds_left !== 8'd40) begin bad++; $display("FAIL solve_frozen_sec got=%0d exp=40", seconds_left); end
        total++; if (hint_level !== 3'd1) begin bad++; $display("FAIL solve_frozen_hl got=%0d exp=1", hint_level); end
        total++; if (timer_done !== 1'b0) begin bad++; $display("FAIL solve_done got=%b exp=0", timer_done); end
        total++; if (round_solved !== 1'b1) begin bad++; $display("FAIL solve_hold got=%b exp=1", round_solved); end
        end_round();
        total++; if (round_solved !== 1'b0) begin bad++; $display("FAIL solve_clr got=%b exp=0", round_solved); end
    endtask

    task automatic test_collision();
        start_round(2'd0);
        repeat (39) do_tick();
        total++; if (seconds_left !== 8'd1) begin bad++; $display("FAIL coll_sec39 got=%0d exp=1", seconds_left); end
        word_correct = 1'b1;
        tick_1hz     = 1'b1;
        @(negedge clk);
        word_correct = 1'b0;
        tick_1hz     = 1'b0;
        total++; if (round_solved !== 1'b1) begin bad++; $display("FAIL coll_solved got=%b exp=1", round_solved); end
        total++; if (timer_done !== 1'b0) begin bad++; $display("FAIL coll_done got=%b exp=0", timer_done); end
        total++; if (seconds_left !== 8'd1) begin bad++; $display("FAIL coll_sec got=%0d exp=1", seconds_left); end
        do_tick();
        total++; if (seconds_left !== 8'd1) begin bad++; $display("FAIL coll_hold_sec got=%0d exp=1", seconds_left); end
        end_round();
    endtask

    task automatic test_reset_mid();
        start_round(2'd0);
        repeat (15) do_tick();
        total++; if (seconds_left !== 8'd25) begin bad++; $display("FAIL rst_pre_sec got=%0d exp=25", seconds_left); end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++; if (seconds_left !== 8'd0) begin bad++; $display("FAIL rst_sec got=%0d exp=0", seconds_left); end
        total++; if (hint_level !== 3'd0) begin bad++; $display("FAIL rst_hl got=%0d exp=0", hint_level); end
        total++; if (hint_start !== 1'b0) begin bad++; $display("FAIL rst_hs got=%b exp=0", hint_start); end
        repeat (5) do_tick();
        total++; if (seconds_left !== 8'd0) begin bad++; $display("FAIL rst_nocount got=%0d exp=0", seconds_left); end
        total++; if (timer_done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", timer_done); end
        end_round();
        start_round(2'd0);
        total++; if (seconds_left !== 8'd40) begin bad++; $display("FAIL rst_restart got=%0d exp=40", seconds_left); end
        do_tick();
        total++; if (seconds_left !== 8'd39) begin bad++; $display("FAIL rst_restart_tick got=%0d exp=39", seconds_left); end
        end_round();
    endtask

`ifdef ROUND_TIMER_WARN_EN
    task automatic test_warn();
        start_round(2'd0);
        repeat (29) do_tick();
        total++; if (warn_blink !== 1'b0) begin bad++; $display("FAIL warn_pre got=%b exp=0", warn_blink); end
        do_tick();
        total++; if (warn_blink !== 1'b1) begin bad++; $display("FAIL warn_entry got=%b exp=1", warn_blink); end
        for (int t = 31; t <= 39; t++) begin
            do_tick();
            total++; if (warn_blink !== (t % 2 == 0)) begin bad++; $display("FAIL warn_t%0d got=%b exp=%b", t, warn_blink, t % 2 == 0); end
        end
        do_tick();
        total++; if (warn_blink !== 1'b0) begin bad++; $display("FAIL warn_expired got=%b exp=0", warn_blink); end
        end_round();
    endtask
`endif

    initial begin
        #1ms;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        tick_1hz     = 1'b0;
        game_start   = 1'b0;
        word_correct = 1'b0;
        timer_sel    = 2'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        test_reset();
        test_full_expiry();
        test_rearm();
        test_solve();
        test_collision();
        test_reset_mid();
`ifdef ROUND_TIMER_WARN_EN
        test_warn();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
